// File: rtl/clock_pkg.sv
// Shared state encoding, field limits and mode sequencing for the clock controller.
// CLOCK_ALARM_EN adds the two alarm-setting states to the mode sequence.
package clock_pkg;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;

  localparam int unsigned ALARM_RING_TICKS = 60;
  localparam int unsigned RING_W           = 6;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2
`ifdef CLOCK_ALARM_EN
    ,
    ST_SET_AL_HR  = 3'd3,
    ST_SET_AL_MIN = 3'd4
`endif
  } state_e;

  // Successor of a state on a mode press; the last SET state returns to RUN.
  function automatic state_e next_mode_state(input state_e s);
    state_e n;
    case (s)
      ST_RUN:        n = ST_SET_HR;
      ST_SET_HR:     n = ST_SET_MIN;
`ifdef CLOCK_ALARM_EN
      ST_SET_MIN:    n = ST_SET_AL_HR;
      ST_SET_AL_HR:  n = ST_SET_AL_MIN;
`endif
      default:       n = ST_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter 0..MAX with synchronous clear (priority over inc) and a wrap carry.
// next_o exposes the value the counter will hold after this edge.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         carry_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    carry_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      if (count_q == W'(MAX)) begin
        count_d = '0;
        carry_o = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/time_set_controller.sv
// Run/set controller owning the hh:mm:ss counters and the two-button edit interface.
// Defining CLOCK_ALARM_EN adds alarm time registers, alarm-set states and the alarm output.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_CYCLES = 500_000,
  parameter int unsigned BLINK_CYCLES  = 250_000
) (
  input  logic            Clk_sys_i,
  input  logic            reset_i,
  input  logic            tick_1sec_i,
  input  logic            btn_mode_i,
  input  logic            btn_inc_i,
  output logic [SEC_W-1:0] seconds_o,
  output logic [MIN_W-1:0] minutes_o,
  output logic [HR_W-1:0]  hours_o,
  output logic [2:0]       state_o,
  output logic             blink_o
`ifdef CLOCK_ALARM_EN
  ,
  input  logic             alarm_on_i,
  output logic             alarm_o
`endif
);

  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
  localparam int unsigned BLK_W = $clog2(BLINK_CYCLES + 1);

  // Button edge detection; bit 0 = mode, bit 1 = inc.
  logic [1:0] btn_lvl;
  logic [1:0] btn_prev_q;
  logic [1:0] btn_press;
  logic       armed_q;

  assign btn_lvl = {btn_inc_i, btn_mode_i};

  // armed_q masks the first cycle after reset so a button held through reset is not a press.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      assign btn_press[gi] = armed_q & btn_lvl[gi] & ~btn_prev_q[gi];
    end
  endgenerate

  logic mode_press;
  logic inc_press;
  logic mode_adv;
  logic alarm_active;

  assign mode_press = btn_press[0];
  assign inc_press  = btn_press[1] & ~mode_press;
  assign mode_adv   = mode_press & ~alarm_active;

  state_e state_q;
  state_e state_d;

  always_comb begin
    state_d = state_q;
    if (mode_adv) begin
      state_d = next_mode_state(state_q);
    end
  end

  logic in_run;
  logic state_changed;
  logic run_tick;

  assign in_run        = (state_q == ST_RUN);
  assign state_changed = (state_d != state_q);
  assign run_tick      = in_run & tick_1sec_i;

  // Auto-repeat: runs while inc is held in a stable SET state.
  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_d;
  logic             rpt_fire;

  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    if (in_run || !btn_inc_i || state_changed) begin
      rpt_cnt_d = '0;
    end else if (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
      rpt_cnt_d = '0;
      rpt_fire  = 1'b1;
    end else begin
      rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
    end
  end

  logic edit_inc;
  assign edit_inc = ~in_run & (inc_press | rpt_fire);

  // Blink runs from the first SET cycle and is held cleared whenever the next state is RUN.
  logic [BLK_W-1:0] blink_cnt_q;
  logic [BLK_W-1:0] blink_cnt_d;
  logic             blink_q;
  logic             blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_d == ST_RUN) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end
  end

  always_ff @(posedge Clk_sys_i) begin
    if (!reset_i) begin
      armed_q     <= 1'b0;
      btn_prev_q  <= '0;
      state_q     <= ST_RUN;
      rpt_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      armed_q     <= 1'b1;
      btn_prev_q  <= btn_lvl;
      state_q     <= state_d;
      rpt_cnt_q   <= rpt_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Time counters: carries chain only in RUN; edits wrap a single field.
  logic             sec_inc, sec_clr, sec_carry;
  logic             min_inc, min_carry;
  logic             hr_inc, hr_carry_unused;
  logic [SEC_W-1:0] sec_next;
  logic [MIN_W-1:0] min_next;
  logic [HR_W-1:0]  hr_next;

  assign sec_inc = run_tick;
  assign sec_clr = ~in_run & (state_d == ST_RUN);
  assign min_inc = (run_tick & sec_carry) | ((state_q == ST_SET_MIN) & edit_inc);
  assign hr_inc  = (run_tick & min_carry) | ((state_q == ST_SET_HR) & edit_inc);

  wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk_i   (Clk_sys_i),
    .rst_ni  (reset_i),
    .inc_i   (sec_inc),
    .clr_i   (sec_clr),
    .count_o (seconds_o),
    .next_o  (sec_next),
    .carry_o (sec_carry)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk_i   (Clk_sys_i),
    .rst_ni  (reset_i),
    .inc_i   (min_inc),
    .clr_i   (1'b0),
    .count_o (minutes_o),
    .next_o  (min_next),
    .carry_o (min_carry)
  );

  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .clk_i   (Clk_sys_i),
    .rst_ni  (reset_i),
    .inc_i   (hr_inc),
    .clr_i   (1'b0),
    .count_o (hours_o),
    .next_o  (hr_next),
    .carry_o (hr_carry_unused)
  );

  assign state_o = state_q;
  assign blink_o = blink_q;

`ifdef CLOCK_ALARM_EN
  logic [HR_W-1:0]   al_hr;
  logic [MIN_W-1:0]  al_min;
  logic [HR_W-1:0]   al_hr_next_unused;
  logic [MIN_W-1:0]  al_min_next_unused;
  logic              al_hr_carry_unused;
  logic              al_min_carry_unused;

  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_al_hr (
    .clk_i   (Clk_sys_i),
    .rst_ni  (reset_i),
    .inc_i   ((state_q == ST_SET_AL_HR) & edit_inc),
    .clr_i   (1'b0),
    .count_o (al_hr),
    .next_o  (al_hr_next_unused),
    .carry_o (al_hr_carry_unused)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_al_min (
    .clk_i   (Clk_sys_i),
    .rst_ni  (reset_i),
    .inc_i   ((state_q == ST_SET_AL_MIN) & edit_inc),
    .clr_i   (1'b0),
    .count_o (al_min),
    .next_o  (al_min_next_unused),
    .carry_o (al_min_carry_unused)
  );

  logic              alarm_q;
  logic              alarm_d;
  logic [RING_W-1:0] ring_cnt_q;
  logic [RING_W-1:0] ring_cnt_d;
  logic              alarm_hit;

  // Compare against the post-tick time so alarm rises together with hh:mm:00.
  assign alarm_hit = run_tick & alarm_on_i & ~mode_press & (sec_next == '0) &
                     (min_next == al_min) & (hr_next == al_hr);

  always_comb begin
    alarm_d    = alarm_q;
    ring_cnt_d = ring_cnt_q;
    if (alarm_q) begin
      if (mode_press || !alarm_on_i) begin
        alarm_d    = 1'b0;
        ring_cnt_d = '0;
      end else if (run_tick) begin
        if (ring_cnt_q == RING_W'(ALARM_RING_TICKS - 1)) begin
          alarm_d    = 1'b0;
          ring_cnt_d = '0;
        end else begin
          ring_cnt_d = ring_cnt_q + RING_W'(1);
        end
      end
    end else if (alarm_hit) begin
      alarm_d    = 1'b1;
      ring_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk_sys_i) begin
    if (!reset_i) begin
      alarm_q    <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      alarm_q    <= alarm_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign alarm_active = alarm_q;
  assign alarm_o      = alarm_q;
`else
  logic [SEC_W+MIN_W+HR_W-1:0] next_unused;
  assign next_unused  = {sec_next, min_next, hr_next};
  assign alarm_active = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// Directed + randomized bench for time_set_controller against a seconds-of-day reference model.
// Build with CLOCK_ALARM_EN defined to exercise the alarm states and outputs.
module tb_time_set_controller;

  localparam int RPT = 4;
  localparam int BLK = 3;
`ifdef CLOCK_ALARM_EN
  localparam int NST = 5;
`else
  localparam int NST = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       bmode = 1'b0;
  logic       binc = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [2:0] st;
  logic       blink;
`ifdef CLOCK_ALARM_EN
  logic       al_on = 1'b0;
  logic       alarm;
`endif

  always #5 clk = ~clk;

  time_set_controller #(.REPEAT_CYCLES(RPT), .BLINK_CYCLES(BLK)) dut (
    .Clk_sys_i   (clk),
    .reset_i     (reset_n),
    .tick_1sec_i (tick),
    .btn_mode_i  (bmode),
    .btn_inc_i   (binc),
    .seconds_o   (sec),
    .minutes_o   (min),
    .hours_o     (hr),
    .state_o     (st),
    .blink_o     (blink)
`ifdef CLOCK_ALARM_EN
    ,
    .alarm_on_i  (al_on),
    .alarm_o     (alarm)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: time as seconds of day, mode as an index, held-cycle counts.
  int m_t = 0;
  int m_st = 0;
  int m_hold = 0;
  int m_setn = 0;
  bit m_pm = 1'b0;
  bit m_pi = 1'b0;
  bit m_armed = 1'b0;
`ifdef CLOCK_ALARM_EN
  int m_alh = 0;
  int m_alm = 0;
  bit m_ring = 1'b0;
  int m_rt = 0;
`endif

  task automatic model_edge();
    bit mp, ip, fire, adv;
    int ost, nst, h, m, s;
    if (!reset_n) begin
      m_t = 0; m_st = 0; m_pm = 0; m_pi = 0; m_armed = 0; m_hold = 0; m_setn = 0;
`ifdef CLOCK_ALARM_EN
      m_alh = 0; m_alm = 0; m_ring = 0; m_rt = 0;
`endif
    end else begin
      mp  = m_armed && bmode && !m_pm;
      ip  = m_armed && binc && !m_pi && !mp;
      adv = mp;
`ifdef CLOCK_ALARM_EN
      if (m_ring) adv = 1'b0;
`endif
      ost = m_st;
      nst = adv ? (ost + 1) % NST : ost;
      if (ost == 0 && tick) m_t = (m_t + 1) % 86400;
      fire = 1'b0;
      if (ost != 0 && nst == ost && binc) begin
        m_hold++;
        fire = ((m_hold % RPT) == 0);
      end else begin
        m_hold = 0;
      end
      if (ost != 0 && (ip || fire)) begin
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        case (ost)
          1: h = (h + 1) % 24;
          2: m = (m + 1) % 60;
`ifdef CLOCK_ALARM_EN
          3: m_alh = (m_alh + 1) % 24;
          4: m_alm = (m_alm + 1) % 60;
`endif
          default: ;
        endcase
        m_t = h * 3600 + m * 60 + s;
      end
      if (ost != 0 && nst == 0) m_t = m_t - (m_t % 60);
`ifdef CLOCK_ALARM_EN
      if (m_ring) begin
        if (mp || !al_on) m_ring = 1'b0;
        else if (ost == 0 && tick) begin
          m_rt++;
          if (m_rt == 60) m_ring = 1'b0;
        end
      end else if (ost == 0 && tick && !mp && al_on && (m_t % 60) == 0 &&
                   (m_t / 60) == (m_alh * 60 + m_alm)) begin
        m_ring = 1'b1;
        m_rt = 0;
      end
`endif
      m_setn = (nst != 0) ? m_setn + 1 : 0;
      m_st = nst; m_pm = bmode; m_pi = binc; m_armed = 1'b1;
    end
  endtask

  task automatic check();
    int eh, em, es, eb;
    eh = m_t / 3600; em = (m_t / 60) % 60; es = m_t % 60;
    eb = (m_setn / BLK) % 2;
    vectors++;
    assert ({hr, min, sec} === {5'(eh), 6'(em), 6'(es)}) else begin
      errors++;
      $error("FAIL time: got %0d:%0d:%0d expected %0d:%0d:%0d", hr, min, sec, eh, em, es);
    end
    vectors++;
    assert (st === 3'(m_st)) else begin
      errors++;
      $error("FAIL state: got %0d expected %0d", st, m_st);
    end
    vectors++;
    assert (blink === 1'(eb)) else begin
      errors++;
      $error("FAIL blink: got %0b expected %0b", blink, eb);
    end
`ifdef CLOCK_ALARM_EN
    vectors++;
    assert (alarm === m_ring) else begin
      errors++;
      $error("FAIL alarm: got %0b expected %0b", alarm, m_ring);
    end
`endif
  endtask

  task automatic step(input bit tk, input bit md, input bit ic);
    tick = tk; bmode = md; binc = ic;
    @(posedge clk);
    model_edge();
    #1;
    check();
  endtask

  task automatic expect_time(input string tag, input int h, input int m, input int s);
    vectors++;
    assert ({hr, min, sec} === {5'(h), 6'(m), 6'(s)}) else begin
      errors++;
      $error("FAIL %s: got %0d:%0d:%0d expected %0d:%0d:%0d", tag, hr, min, sec, h, m, s);
    end
  endtask

  task automatic expect_state(input string tag, input int s);
    vectors++;
    assert (st === 3'(s)) else begin
      errors++;
      $error("FAIL %s: state got %0d expected %0d", tag, st, s);
    end
  endtask

  task automatic press_mode();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    $display("mode press -> state %0d time %0d:%0d:%0d", st, hr, min, sec);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    $display("%0d inc presses -> state %0d time %0d:%0d:%0d", n, st, hr, min, sec);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0);
    end
    $display("%0d ticks -> state %0d time %0d:%0d:%0d", n, st, hr, min, sec);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    $display("reset -> state %0d time %0d:%0d:%0d blink %0b", st, hr, min, sec, blink);
  endtask

  task automatic to_run();
    for (int i = 0; i < NST && m_st != 0; i++) press_mode();
  endtask

  initial begin
    bit [1:0] seen;
    bit       ic;

    // Reset with mode held: release must not produce a press.
    reset_n = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    expect_time("reset_time", 0, 0, 0);
    expect_state("reset_state", 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    expect_state("held_through_reset", 0);
    step(1'b0, 1'b0, 1'b0);
    $display("held mode through reset -> state %0d", st);

    ticks(60);
    expect_time("sixty_ticks", 0, 1, 0);
    expect_state("run_after_ticks", 0);

    // Preload 23:59:58 through the edit UI.
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(58);
    to_run();
    expect_time("preload_clears_sec", 23, 59, 0);
    ticks(58);
    expect_time("preload", 23, 59, 58);
    ticks(2);
    expect_time("day_wrap", 0, 0, 0);

    // Tick coinciding with RUN->SET_HR is applied; then clock frozen while editing.
    step(1'b1, 1'b1, 1'b0);
    expect_time("tick_on_enter_set", 0, 0, 1);
    expect_state("enter_set_hr", 1);
    step(1'b0, 1'b0, 1'b0);
    press_inc(3);
    seen = 2'b00;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 1'b0, 1'b0);
      seen[blink] = 1'b1;
    end
    expect_time("frozen_in_set", 3, 0, 1);
    vectors++;
    assert (seen === 2'b11) else begin
      errors++;
      $error("FAIL blink_toggle: seen %b expected 11", seen);
    end
    to_run();
    expect_time("exit_set_clears_sec", 3, 0, 0);

    // Auto-repeat in SET_MIN, then tick on the exit press is dropped.
    ticks(5);
    press_mode();
    press_mode();
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    $display("inc held 13 cycles -> time %0d:%0d:%0d", hr, min, sec);
    expect_time("auto_repeat", 3, 4, 5);
`ifdef CLOCK_ALARM_EN
    press_mode();
    press_mode();
`endif
    step(1'b1, 1'b1, 1'b0);
    expect_time("tick_on_exit_dropped", 3, 4, 0);
    expect_state("exit_to_run", 0);
    step(1'b0, 1'b0, 1'b0);

    // Both buttons together: mode wins.
    press_mode();
    step(1'b0, 1'b1, 1'b1);
    expect_state("both_buttons_mode_wins", 2);
    expect_time("both_buttons_no_inc", 3, 4, 0);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-SET_HR.
    to_run();
    press_mode();
    press_inc(2);
    do_reset();
    expect_time("reset_mid_set", 0, 0, 0);
    expect_state("reset_mid_set_state", 0);

`ifdef CLOCK_ALARM_EN
    press_mode();  press_inc(7);
    press_mode();  press_inc(29);
    press_mode();  press_inc(7);
    press_mode();  press_inc(30);
    press_mode();
    al_on = 1'b1;
    ticks(59);
    expect_time("pre_alarm", 7, 29, 59);
    step(1'b1, 1'b0, 1'b0);
    vectors++;
    assert (alarm === 1'b1) else begin
      errors++;
      $error("FAIL alarm_ring: got %0b expected 1", alarm);
    end
    press_mode();
    vectors++;
    assert (alarm === 1'b0) else begin
      errors++;
      $error("FAIL alarm_silence: got %0b expected 0", alarm);
    end
    expect_state("silence_stays_run", 0);
`endif

    // Randomized phase against the model.
    ic = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 7) == 0) ic = ~ic;
`ifdef CLOCK_ALARM_EN
      if ($urandom_range(0, 199) == 0) al_on = ~al_on;
`endif
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), ic);
      if (i % 500 == 499) $display("random cycle %0d -> state %0d time %0d:%0d:%0d", i + 1, st, hr, min, sec);
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
